// File: rtl/mul255_seq.sv
// Byte-serial y*255 = (y<<8) - y, one byte per cycle.
// Optional: MUL255_CHECK_EN adds x_ref input and match output.
module mul255_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   y,
`ifdef MUL255_CHECK_EN
  input  logic [8*NBYTES-1:0]   x_ref,
  output logic                  match,
`endif
  output logic                  busy,
  output logic                  valid,
  output logic [8*NBYTES-1:0]   p,
  output logic                  ovf
);

  localparam int W = 8 * NBYTES;

  typedef enum logic [2:0] {
    IDLE, B0, B1, B2, B3, TOP, DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   yreg;
  logic           brw;
`ifdef MUL255_CHECK_EN
  logic [W-1:0]   xreg;
`endif

  logic [1:0]     bi;
  logic [4:0]     cur_idx;
  logic [4:0]     lo_idx;
  logic [7:0]     ycur;
  logic [7:0]     ylo;
  logic [8:0]     diff;
  logic [7:0]     top;

  // Byte select and the shared 8-bit subtract-with-borrow datapath
  always_comb begin
    bi = 2'd0;
    unique case (state)
      B1:      bi = 2'd1;
      B2:      bi = 2'd2;
      B3:      bi = 2'd3;
      default: bi = 2'd0;
    endcase
    cur_idx = {bi, 3'b000};
    lo_idx  = cur_idx - 5'd8;
    ycur    = yreg[cur_idx +: 8];
    ylo     = (bi == 2'd0) ? 8'h00 : yreg[lo_idx +: 8];
    diff    = {1'b0, ylo} - {1'b0, ycur} - {8'h00, brw};
    top     = yreg[W-1 -: 8] - {7'b0, brw};
  end

  // Control FSM with registered result, flags and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      yreg  <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      valid <= 1'b0;
      p     <= '0;
      ovf   <= 1'b0;
`ifdef MUL255_CHECK_EN
      xreg  <= '0;
      match <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            yreg  <= y;
            brw   <= 1'b0;
            busy  <= 1'b1;
            state <= B0;
`ifdef MUL255_CHECK_EN
            xreg  <= x_ref;
`endif
          end
        end
        B0: begin
          p[cur_idx +: 8] <= diff[7:0];
          brw   <= diff[8];
          state <= B1;
        end
        B1: begin
          p[cur_idx +: 8] <= diff[7:0];
          brw   <= diff[8];
          state <= B2;
        end
        B2: begin
          p[cur_idx +: 8] <= diff[7:0];
          brw   <= diff[8];
          state <= B3;
        end
        B3: begin
          p[cur_idx +: 8] <= diff[7:0];
          brw   <= diff[8];
          state <= TOP;
        end
        TOP: begin
          ovf   <= (top != 8'h00);
          valid <= 1'b1;
`ifdef MUL255_CHECK_EN
          match <= (p == xreg) && (top == 8'h00);
`endif
          state <= DONE;
        end
        DONE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul255_seq.sv
// Bench for mul255_seq: directed literal cases plus
// randomized traffic checked against a cycle-level model.
module tb_mul255_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] y;
  logic        busy;
  logic        valid;
  logic [31:0] p;
  logic        ovf;
`ifdef MUL255_CHECK_EN
  logic [31:0] x_ref;
  logic        match;
`endif

  int checks = 0;
  int errors = 0;

  mul255_seq #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .y     (y),
`ifdef MUL255_CHECK_EN
    .x_ref (x_ref),
    .match (match),
`endif
    .busy  (busy),
    .valid (valid),
    .p     (p),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: cycles since acceptance (-1 = idle), expected results
  int          mn;
  logic [39:0] pend;
  logic [31:0] m_p;
  logic        m_ovf;
  logic [31:0] pxref;
  logic        m_match;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mn      = -1;
      m_p     = '0;
      m_ovf   = 1'b0;
      m_match = 1'b0;
      pend    = '0;
      pxref   = '0;
    end else if (mn >= 0) begin
      mn = mn + 1;
      if (mn == 5) begin
        m_p     = pend[31:0];
        m_ovf   = |pend[39:32];
        m_match = (pend[31:0] == pxref) && !m_ovf;
      end else if (mn == 6) begin
        mn = -1;
      end
    end else if (start) begin
      mn   = 0;
      pend = 40'(y) * 40'd255;
`ifdef MUL255_CHECK_EN
      pxref = x_ref;
`else
      pxref = '0;
`endif
    end
  end

  // Compare every cycle; p/ovf only when not mid-computation
  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, (mn >= 0)});
    chk("valid", {31'b0, valid}, {31'b0, (mn == 5)});
    if (mn < 0 || mn == 5) begin
      chk("p", p, m_p);
      chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
`ifdef MUL255_CHECK_EN
      chk("match", {31'b0, match}, {31'b0, m_match});
`endif
    end
  end

  logic [31:0] r_p;
  logic        r_ovf;
  logic        r_match;
  int          r_bcnt;
  int          r_vat;

  task automatic wait_done();
    r_bcnt = 0;
    r_vat  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) r_bcnt++;
      if (valid) begin
        r_vat = i;
        r_p   = p;
        r_ovf = ovf;
`ifdef MUL255_CHECK_EN
        r_match = match;
`else
        r_match = 1'b0;
`endif
      end
      if (!busy) break;
    end
  endtask

  task automatic do_op(input logic [31:0] yv, input logic [31:0] xr,
                       input logic [31:0] ep, input logic eo);
    @(posedge clk);
    #1;
    start = 1'b1;
    y     = yv;
`ifdef MUL255_CHECK_EN
    x_ref = xr;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    y     = $urandom;
    wait_done();
    chk("lat", r_vat, 6);
    chk("busycnt", r_bcnt, 6);
    chk("lit_p", r_p, ep);
    chk("lit_ovf", {31'b0, r_ovf}, {31'b0, eo});
  endtask

  logic [31:0] sel [0:5];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    y     = '0;
`ifdef MUL255_CHECK_EN
    x_ref = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_p", p, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    rst_n = 1'b1;

    do_op(32'h00000001, 32'h0, 32'h000000FF, 1'b0);
    do_op(32'h01010101, 32'h0, 32'hFFFFFFFF, 1'b0);
    do_op(32'h00000000, 32'h0, 32'h00000000, 1'b0);
    do_op(32'h01010102, 32'h0, 32'h000000FE, 1'b1);
    do_op(32'hFFFFFFFF, 32'h0, 32'hFFFFFF01, 1'b1);

    // Start while busy is ignored
    @(posedge clk);
    #1;
    start = 1'b1;
    y     = 32'h00000002;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    y     = 32'h00000005;
    @(posedge clk);
    #1;
    start = 1'b0;
    y     = '0;
    wait_done();
    chk("ign_p", r_p, 32'h000001FE);
    chk("ign_ovf", {31'b0, r_ovf}, 32'd0);
    do_op(32'h00000005, 32'h0, 32'h000004FB, 1'b0);

    // Reset during B2
    @(posedge clk);
    #1;
    start = 1'b1;
    y     = 32'h12345678;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_valid", {31'b0, valid}, 32'd0);
    chk("mid_p", p, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op(32'h00000003, 32'h0, 32'h000002FD, 1'b0);

`ifdef MUL255_CHECK_EN
    do_op(32'h00000003, 32'h000002FD, 32'h000002FD, 1'b0);
    chk("m_eq", {31'b0, r_match}, 32'd1);
    do_op(32'h00000003, 32'h000002FE, 32'h000002FD, 1'b0);
    chk("m_ne", {31'b0, r_match}, 32'd0);
    do_op(32'h01010102, 32'h000000FE, 32'h000000FE, 1'b1);
    chk("m_ovf", {31'b0, r_match}, 32'd0);
`endif

    // Randomized traffic, including spurious starts and resets
    sel[0] = 32'h01010101;
    sel[1] = 32'h01010102;
    sel[2] = 32'hFFFFFFFF;
    sel[3] = 32'h00000000;
    sel[4] = 32'h01010100;
    sel[5] = 32'h00FFFFFF;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      rst_n = !((c % 600) == 599);
      start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0)
        y = sel[$urandom_range(0, 5)];
      else
        y = $urandom;
`ifdef MUL255_CHECK_EN
      x_ref = $urandom_range(0, 1) ? (y * 32'd255) : $urandom;
`endif
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
